// File: rtl/uart_pkg.sv
// Shared types for uart_core: parity encodings, TX/RX FSM states and the RX entry record.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rxState_t;

    typedef struct packed {
        logic [7:0] data;
        logic       parityErr;
        logic       frameErr;
    } rxEntry_t;

    // Expects unused upper data bits already cleared.
    function automatic logic parityBit(input logic [7:0] d, input int parity);
        return (parity == PARITY_ODD) ? ~(^d) : ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO of rxEntry_t; pointers carry one extra wrap bit for full/empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  rxEntry_t pushEntry,
    input  logic     pop,
    output rxEntry_t head,
    output logic     empty,
    output logic     overrun
);

    localparam int AW = $clog2(DEPTH);

    rxEntry_t       mem [DEPTH];
    logic [AW:0]    wrPtr;
    logic [AW:0]    rdPtr;
    logic           full;
    logic           doPush;
    logic           doPop;

    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop   = pop && !empty;
    // A simultaneous pop frees the slot the push needs.
    assign doPush  = push && (!full || doPop);
    assign overrun = push && full && !doPop;
    assign head    = empty ? '0 : mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushEntry;
    end

endmodule

// File: rtl/uart_core.sv
// Configurable full-duplex UART (5..8 data bits, none/odd/even parity, 1 or 2 stop bits).
// Define UART_CORE_RX_FIFO_EN to buffer received frames in uart_rx_fifo.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 234,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int             CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]     DATA_MASK  = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]     DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]     STOP_LAST  = 3'(STOP_BITS - 1);
    localparam bit             HAS_PARITY = (PARITY != PARITY_NONE);

    txState_t      txState, txStateNext;
    logic [CW-1:0] txCnt, txCntNext;
    logic [2:0]    txIdx, txIdxNext;
    logic [7:0]    txShift, txShiftNext;
    logic          txPar, txParNext;
    logic          txLine, txLineNext;
    logic          txBitDone;

    always_comb begin
        txStateNext = txState;
        txCntNext   = txCnt + 1'b1;
        txIdxNext   = txIdx;
        txShiftNext = txShift;
        txParNext   = txPar;
        txBitDone   = (txCnt == BIT_LAST);
        case (txState)
            TX_IDLE: begin
                txCntNext = '0;
                txIdxNext = '0;
                if (tx_valid) begin
                    txStateNext = TX_START;
                    txShiftNext = tx_data & DATA_MASK;
                    txParNext   = parityBit(tx_data & DATA_MASK, PARITY);
                end
            end
            TX_START: if (txBitDone) begin
                txCntNext   = '0;
                txStateNext = TX_DATA;
            end
            TX_DATA: if (txBitDone) begin
                txCntNext   = '0;
                txShiftNext = txShift >> 1;
                if (txIdx == DATA_LAST) begin
                    txIdxNext   = '0;
                    txStateNext = HAS_PARITY ? TX_PARITY : TX_STOP;
                end else begin
                    txIdxNext = txIdx + 3'd1;
                end
            end
            TX_PARITY: if (txBitDone) begin
                txCntNext   = '0;
                txStateNext = TX_STOP;
            end
            TX_STOP: if (txBitDone) begin
                txCntNext = '0;
                if (txIdx == STOP_LAST) begin
                    txIdxNext   = '0;
                    txStateNext = TX_IDLE;
                end else begin
                    txIdxNext = txIdx + 3'd1;
                end
            end
            default: txStateNext = TX_IDLE;
        endcase
        // Line level is registered from the next state so the pin never glitches.
        case (txStateNext)
            TX_START:  txLineNext = 1'b0;
            TX_DATA:   txLineNext = txShiftNext[0];
            TX_PARITY: txLineNext = txParNext;
            default:   txLineNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txState <= TX_IDLE;
            txCnt   <= '0;
            txIdx   <= '0;
            txLine  <= 1'b1;
        end else begin
            txState <= txStateNext;
            txCnt   <= txCntNext;
            txIdx   <= txIdxNext;
            txLine  <= txLineNext;
        end
    end

    always_ff @(posedge clk) begin
        txShift <= txShiftNext;
        txPar   <= txParNext;
    end

    assign uart_tx  = txLine;
    assign tx_ready = (txState == TX_IDLE);

    // Input synchronizer stage
    logic rxSync_p0, rxSync_p1;
    logic rxIn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxSync_p0 <= 1'b1;
            rxSync_p1 <= 1'b1;
        end else begin
            rxSync_p0 <= uart_rx;
            rxSync_p1 <= rxSync_p0;
        end
    end

    assign rxIn = rxSync_p1;

    rxState_t      rxState, rxStateNext;
    logic [CW-1:0] rxCnt, rxCntNext;
    logic [2:0]    rxIdx, rxIdxNext;
    logic [7:0]    rxShift, rxShiftNext;
    logic          rxPar, rxParNext;
    logic          frameVld_p0, frameVldNext;
    rxEntry_t      frameEntry_p0, frameEntryNext;
    logic          rxBitDone;

    always_comb begin
        rxStateNext    = rxState;
        rxCntNext      = rxCnt + 1'b1;
        rxIdxNext      = rxIdx;
        rxShiftNext    = rxShift;
        rxParNext      = rxPar;
        frameVldNext   = 1'b0;
        frameEntryNext = frameEntry_p0;
        rxBitDone      = (rxCnt == BIT_LAST);
        case (rxState)
            RX_IDLE: begin
                rxCntNext = '0;
                rxIdxNext = '0;
                if (!rxIn) begin
                    rxStateNext = RX_START;
                    rxShiftNext = '0;
                end
            end
            RX_START: if (rxCnt == HALF_LAST) begin
                rxCntNext   = '0;
                rxStateNext = rxIn ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rxBitDone) begin
                rxCntNext          = '0;
                rxShiftNext[rxIdx] = rxIn;
                if (rxIdx == DATA_LAST) begin
                    rxIdxNext   = '0;
                    rxStateNext = HAS_PARITY ? RX_PARITY : RX_STOP;
                end else begin
                    rxIdxNext = rxIdx + 3'd1;
                end
            end
            RX_PARITY: if (rxBitDone) begin
                rxCntNext   = '0;
                rxParNext   = rxIn;
                rxStateNext = RX_STOP;
            end
            RX_STOP: if (rxBitDone) begin
                rxCntNext                = '0;
                rxStateNext              = RX_IDLE;
                frameVldNext             = 1'b1;
                frameEntryNext.data      = rxShift;
                frameEntryNext.parityErr = HAS_PARITY && (rxPar != parityBit(rxShift, PARITY));
                frameEntryNext.frameErr  = !rxIn;
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxState       <= RX_IDLE;
            rxCnt         <= '0;
            rxIdx         <= '0;
            frameVld_p0   <= 1'b0;
            frameEntry_p0 <= '0;
        end else begin
            rxState       <= rxStateNext;
            rxCnt         <= rxCntNext;
            rxIdx         <= rxIdxNext;
            frameVld_p0   <= frameVldNext;
            frameEntry_p0 <= frameEntryNext;
        end
    end

    always_ff @(posedge clk) begin
        rxShift <= rxShiftNext;
        rxPar   <= rxParNext;
    end

    // Delivery stage
`ifdef UART_CORE_RX_FIFO_EN
    rxEntry_t fifoHead;
    logic     fifoEmpty;

    uart_rx_fifo #(
        .DEPTH(RX_FIFO_DEPTH)
    ) u_rxFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (frameVld_p0),
        .pushEntry(frameEntry_p0),
        .pop      (rx_valid && rx_ready),
        .head     (fifoHead),
        .empty    (fifoEmpty),
        .overrun  (rx_overrun)
    );

    assign rx_valid      = !fifoEmpty;
    assign rx_data       = fifoHead.data;
    assign rx_parity_err = fifoHead.parityErr;
    assign rx_frame_err  = fifoHead.frameErr;
`else
    localparam int unusedDepth = RX_FIFO_DEPTH;
    logic unusedRxReady;

    assign unusedRxReady = rx_ready;
    assign rx_valid      = frameVld_p0;
    assign rx_data       = frameEntry_p0.data;
    assign rx_parity_err = frameEntry_p0.parityErr;
    assign rx_frame_err  = frameEntry_p0.frameErr;
    assign rx_overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: three instances (8N1 loopback, 7E2 loopback, 8O1 driven by the bench).
module tb_uart_core;

    localparam int CPB = 16;
    localparam int CDB  [3] = '{8, 7, 8};
    localparam int CPAR [3] = '{0, 2, 1};
    localparam int CSB  [3] = '{1, 2, 1};

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0][7:0] txData;
    logic [2:0]      txValid;
    logic [2:0]      txReady;
    logic [2:0]      txLine;
    logic [2:0][7:0] rxData;
    logic [2:0]      rxValid;
    logic [2:0]      rxReady;
    logic [2:0]      rxPe;
    logic [2:0]      rxFe;
    logic [2:0]      rxOvr;
    logic [2:0]      rxTake;
    logic            rxLineC;

    int passed = 0;
    int total  = 0;
    int ovrCount [3] = '{0, 0, 0};
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    always #5 clk = ~clk;

    uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) dutA (
        .clk(clk), .rst_n(rst_n), .uart_rx(txLine[0]), .uart_tx(txLine[0]),
        .tx_data(txData[0]), .tx_valid(txValid[0]), .tx_ready(txReady[0]),
        .rx_data(rxData[0]), .rx_valid(rxValid[0]), .rx_ready(rxReady[0]),
        .rx_parity_err(rxPe[0]), .rx_frame_err(rxFe[0]), .rx_overrun(rxOvr[0]));

    uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .RX_FIFO_DEPTH(4)) dutB (
        .clk(clk), .rst_n(rst_n), .uart_rx(txLine[1]), .uart_tx(txLine[1]),
        .tx_data(txData[1]), .tx_valid(txValid[1]), .tx_ready(txReady[1]),
        .rx_data(rxData[1]), .rx_valid(rxValid[1]), .rx_ready(rxReady[1]),
        .rx_parity_err(rxPe[1]), .rx_frame_err(rxFe[1]), .rx_overrun(rxOvr[1]));

    uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) dutC (
        .clk(clk), .rst_n(rst_n), .uart_rx(rxLineC), .uart_tx(txLine[2]),
        .tx_data(txData[2]), .tx_valid(txValid[2]), .tx_ready(txReady[2]),
        .rx_data(rxData[2]), .rx_valid(rxValid[2]), .rx_ready(rxReady[2]),
        .rx_parity_err(rxPe[2]), .rx_frame_err(rxFe[2]), .rx_overrun(rxOvr[2]));

`ifdef UART_CORE_RX_FIFO_EN
    assign rxTake = rxValid & rxReady;
`else
    assign rxTake = rxValid;
`endif

    // Record every delivered frame as {data, parity_err, frame_err}.
    always @(negedge clk) begin
        if (rxTake[0]) q0.push_back({rxData[0], rxPe[0], rxFe[0]});
        if (rxTake[1]) q1.push_back({rxData[1], rxPe[1], rxFe[1]});
        if (rxTake[2]) q2.push_back({rxData[2], rxPe[2], rxFe[2]});
        for (int u = 0; u < 3; u++) if (rxOvr[u]) ovrCount[u]++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic int qsize(input int u);
        case (u)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [9:0] qpop(input int u);
        case (u)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Serial line image of one frame, one entry per bit period.
    function automatic int buildFrame(input int u, input logic [7:0] b, output logic [15:0] bits);
        int n = 0;
        int ones = 0;
        bits = '1;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < CDB[u]; i++) begin
            bits[n] = b[i];
            ones += int'(b[i]);
            n++;
        end
        if (CPAR[u] == 1) begin
            bits[n] = (ones % 2 == 0);
            n++;
        end else if (CPAR[u] == 2) begin
            bits[n] = (ones % 2 == 1);
            n++;
        end
        n += CSB[u];
        return n;
    endfunction

    function automatic logic [7:0] maskData(input int u, input logic [7:0] b);
        return 8'(int'(b) % (1 << CDB[u]));
    endfunction

    task automatic waitReady(input int u);
        int w = 0;
        while (!txReady[u] && w < 2000) begin
            tick();
            w++;
        end
        check("tx_ready_wait", txReady[u], 1);
    endtask

    task automatic sendFrame(input int u, input logic [7:0] b);
        logic [15:0] bits;
        int n;
        n = buildFrame(u, b, bits);
        waitReady(u);
        txData[u]  = b;
        txValid[u] = 1'b1;
        tick();
        txValid[u] = 1'b0;
        check("tx_ready_busy", txReady[u], 0);
        for (int k = 0; k < n * CPB; k++) begin
            check($sformatf("tx_line_u%0d_c%0d", u, k), txLine[u], bits[k / CPB]);
            tick();
        end
        check("tx_ready_after_frame", txReady[u], 1);
    endtask

    task automatic injectFrame(input logic [7:0] b, input logic flipPar, input logic stopLow);
        logic [15:0] bits;
        int n;
        n = buildFrame(2, b, bits);
        bits[n - 2] = bits[n - 2] ^ flipPar;
        bits[n - 1] = !stopLow;
        for (int i = 0; i < n; i++) begin
            rxLineC = bits[i];
            repeat (CPB) tick();
        end
        rxLineC = 1'b1;
        repeat (3 * CPB) tick();
    endtask

    task automatic expectRx(input int u, input logic [7:0] b, input logic pe, input logic fe);
        logic [9:0] got;
        int w = 0;
        while (qsize(u) == 0 && w < 400) begin
            tick();
            w++;
        end
        check($sformatf("rx_delivered_u%0d", u), qsize(u) != 0, 1);
        if (qsize(u) != 0) begin
            got = qpop(u);
            check($sformatf("rx_data_u%0d", u), got[9:2], maskData(u, b));
            check($sformatf("rx_parity_err_u%0d", u), got[1], pe);
            check($sformatf("rx_frame_err_u%0d", u), got[0], fe);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] bs [5];

        rst_n   = 1'b0;
        txValid = '0;
        txData  = '0;
        rxReady = 3'b111;
        rxLineC = 1'b1;
        repeat (3) tick();
        for (int u = 0; u < 3; u++) begin
            check($sformatf("reset_uart_tx_u%0d", u), txLine[u], 1);
            check($sformatf("reset_tx_ready_u%0d", u), txReady[u], 1);
            check($sformatf("reset_rx_valid_u%0d", u), rxValid[u], 0);
            check($sformatf("reset_rx_data_u%0d", u), rxData[u], 0);
            check($sformatf("reset_rx_parity_err_u%0d", u), rxPe[u], 0);
            check($sformatf("reset_rx_frame_err_u%0d", u), rxFe[u], 0);
            check($sformatf("reset_rx_overrun_u%0d", u), rxOvr[u], 0);
        end
        rst_n = 1'b1;
        tick();

        sendFrame(0, 8'hA5);
        expectRx(0, 8'hA5, 1'b0, 1'b0);
        repeat (3) begin
            b = 8'($urandom);
            sendFrame(0, b);
            expectRx(0, b, 1'b0, 1'b0);
        end

        sendFrame(1, 8'h3C);
        expectRx(1, 8'h3C, 1'b0, 1'b0);
        repeat (2) begin
            b = 8'($urandom);
            sendFrame(1, b);
            expectRx(1, b, 1'b0, 1'b0);
        end

        injectFrame(8'h01, 1'b1, 1'b0);
        expectRx(2, 8'h01, 1'b1, 1'b0);
        b = 8'($urandom);
        injectFrame(b, 1'b0, 1'b1);
        expectRx(2, b, 1'b0, 1'b1);
        b = 8'($urandom);
        injectFrame(b, 1'b0, 1'b0);
        expectRx(2, b, 1'b0, 1'b0);

        rxLineC = 1'b0;
        repeat (4) tick();
        rxLineC = 1'b1;
        repeat (10) tick();
        check("glitch_no_delivery", qsize(2), 0);
        b = 8'($urandom);
        injectFrame(b, 1'b0, 1'b0);
        expectRx(2, b, 1'b0, 1'b0);

`ifdef UART_CORE_RX_FIFO_EN
        check("overrun_none_yet", ovrCount[2], 0);
        rxReady[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bs[i] = 8'($urandom);
            injectFrame(bs[i], 1'b0, 1'b0);
        end
        check("overrun_pulses", ovrCount[2], 1);
        check("fifo_rx_valid_full", rxValid[2], 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fifo_head_%0d", i), rxData[2], bs[i]);
            rxReady[2] = 1'b1;
            tick();
            rxReady[2] = 1'b0;
        end
        check("fifo_drained", rxValid[2], 0);
        q2.delete();
`else
        bs[0] = b;
        repeat (20) tick();
        check("rx_data_held", rxData[2], bs[0]);
        check("rx_valid_is_pulse", rxValid[2], 0);
        check("overrun_tied_low", ovrCount[0] + ovrCount[1] + ovrCount[2], 0);
`endif

        waitReady(0);
        txData[0]  = 8'h00;
        txValid[0] = 1'b1;
        tick();
        txValid[0] = 1'b0;
        repeat (50) tick();
        check("tx_low_mid_frame", txLine[0], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("tx_high_async_reset", txLine[0], 1);
        tick();
        rst_n = 1'b1;
        tick();
        check("tx_ready_after_reset", txReady[0], 1);
        repeat (200) tick();
        check("no_rx_from_partial", qsize(0), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
